pipelined_rr_arbiter: RTL and testbench
=======================================

// Module: pipelined_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one pipelined server (e.g. coefficient/sample memory) among
//   N_CLIENTS requesters and keeps up to MAX_OUTSTANDING requests in flight.
//   Responses return in issue order. A tag FIFO routes each response back to the issuing client.
//   Replaces stop-and-wait arbitration where server throughput matters.
// PARAMETERS
//   REQ_DATA_WIDTH     16  request payload width (address/command)
//   SERVER_DATA_WIDTH  16  response data width
//   N_CLIENTS          32  number of requesters, >= 2
//   MAX_OUTSTANDING    4   in-flight limit; power of 2, >= 2
// PORTS
//   clk                in   1                             single clock, all logic on posedge
//   reset              in   1                             asynchronous, active-low (0 = reset)
//   req_data_flat      in   N_CLIENTS*REQ_DATA_WIDTH      client i payload at [i*W +: W]
//   reqs               in   N_CLIENTS                     per-client request level
//   data_out           out  SERVER_DATA_WIDTH             response data, valid with readies pulse
//   readies            out  N_CLIENTS                     one-hot 1-cycle pulse: response for client i
//   arbiter_req_data   out  REQ_DATA_WIDTH                payload issued to server
//   arbiter_req        out  1                             1-cycle issue strobe to server
//   server_stall       in   1                             server cannot accept this cycle
//   server_data        in   SERVER_DATA_WIDTH             server response data
//   server_ready       in   1                             1-cycle pulse: response for oldest request
//   outstanding        out  $clog2(MAX_OUTSTANDING)+1     current in-flight count
//   spurious_ready     out  1                             sticky: server_ready seen with nothing in flight
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - All outputs 0.
//   - Pointer = 0, pending mask = 0, tag FIFO empty.
// - Eligibility:
//   - eligible = reqs & ~pending & ~readies.
//   - Each client has at most one request in flight.
//   - Masking with readies stops a client from being re-granted in the cycle its response pulse is high.
// - Issue condition: |eligible && outstanding < MAX_OUTSTANDING && !server_stall.
//   - Winner = first eligible index searching upward from pointer, wrapping N_CLIENTS-1 -> 0.
// - On issue (cycle t sample, t+1 output):
//   - arbiter_req = 1 for exactly one cycle.
//   - arbiter_req_data = winner's payload.
//   - Push winner id into tag FIFO and set pending[winner].
//   - Pointer = winner+1, wrapping to 0 after N_CLIENTS-1.
// - No issue: arbiter_req = 0; pointer and arbiter_req_data hold.
// - Maximum issue rate is one request per cycle.
// - On server_ready (cycle t sample, t+1 output):
//   - Pop FIFO head h; data_out = server_data.
//   - readies[h] = 1 for one cycle; clear pending[h].
//   - data_out holds until the next response.
// - Outstanding count:
//   - Push and pop in the same cycle: count unchanged, both actions performed.
//   - Push alone: +1. Pop alone: -1.
//   - Never exceeds MAX_OUTSTANDING.
// - server_ready while outstanding == 0:
//   - No pop and no readies pulse.
//   - Set spurious_ready; it clears only on reset.
// - Requester contract:
//   - Hold reqs and payload stable until the readies pulse.
//   - reqs still high after the readies cycle is a new request.
// - Server contract:
//   - Responses in issue order, latency >= 1 cycle.
//   - server_stall is sampled in the same cycle as issue selection.
// - Reset mid-operation:
//   - In-flight tags and pending state are discarded.
//   - The server must be reset with this block. Late responses are flagged spurious, never delivered.
// - Latency: request to arbiter_req is 1 cycle minimum; server_ready to readies is 1 cycle.
// STRUCTURE
// - Shared package arbiter_pkg holds:
//   - Client id width function (clog2, minimum 1).
//   - rr_find_first(mask, ptr) rotating find-first function, also reused by the other arbiters.
// - Sub-module tag_fifo: synchronous FIFO, depth MAX_OUTSTANDING, width client id.
//   - Push/pop/full/empty/count; simultaneous push+pop allowed when not empty.
// - Top level: eligibility mask, pointer register, issue register, pending mask, response demux.
// TESTING
// - Single client:
//   - reqs=0x1, payload 0x0042, server latency 3.
//   - Expect arbiter_req 1 cycle later with data 0x0042.
//   - Expect readies=0x1 one cycle after server_ready.
//   - Expect no second issue before that readies pulse.
// - Fairness and pipelining:
//   - reqs=0xFFFFFFFF, MAX_OUTSTANDING=4, latency 4.
//   - Expect grant order 0,1,2,3,4... with issues back-to-back.
//   - Expect outstanding saturates at 4, then one issue per response.
// - Wrap-around:
//   - Pointer at 30, reqs = bits 31 and 2.
//   - Expect grants 31 then 2, and readies pulses in order 31, 2.
// - Back-pressure and simultaneous events:
//   - server_stall held high for 5 cycles: expect no arbiter_req.
//   - server_ready arriving in the same cycle as an issue: expect outstanding unchanged and correct readies routing.
// - Spurious response: server_ready with empty FIFO.
//   - Expect no readies pulse.
//   - Expect spurious_ready=1 until reset.
// - Reset mid-flight:
//   - Drive reset=0 with 3 requests outstanding.
//   - Expect all outputs 0, outstanding=0, pointer 0.
//   - Expect new requests issue normally afterwards.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared arbitration helpers: client-id sizing and a rotating find-first search.
package arbiter_pkg;

  localparam int unsigned RR_MAX_N = 128;
  localparam int unsigned RR_IDW   = $clog2(RR_MAX_N);

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Returns the first set bit of mask[n-1:0] at or above ptr, wrapping n-1 -> 0.
  // Callers must check the mask is non-zero; ptr is returned otherwise.
  function automatic int unsigned rr_find_first(input logic [RR_MAX_N-1:0] mask,
                                                input int unsigned n,
                                                input int unsigned ptr);
    int unsigned idx;
    logic        found;
    rr_find_first = ptr;
    found         = 1'b0;
    for (int unsigned i = 0; i < RR_MAX_N; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && mask[idx[RR_IDW-1:0]]) begin
          found         = 1'b1;
          rr_find_first = idx;
        end
      end
    end
  endfunction

endpackage

// File: rtl/pipelined_rr_arbiter_tag_fifo.sv
// Synchronous tag FIFO holding the client id of each in-flight request, oldest at the head.
module tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_q];

  always_comb begin
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && !empty_o;
    rd_d    = pop_ok  ? rd_q + 1'b1 : rd_q;
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/pipelined_rr_arbiter.sv
// Round-robin arbiter feeding one pipelined server with several requests in flight;
// in-order responses are routed back to their issuer through a tag FIFO.
module pipelined_rr_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned REQ_DATA_WIDTH    = 16,
  parameter int unsigned SERVER_DATA_WIDTH = 16,
  parameter int unsigned N_CLIENTS         = 32,
  parameter int unsigned MAX_OUTSTANDING   = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_CLIENTS*REQ_DATA_WIDTH-1:0] req_data_flat,
  input  logic [N_CLIENTS-1:0]                reqs,
  output logic [SERVER_DATA_WIDTH-1:0]        data_out,
  output logic [N_CLIENTS-1:0]                readies,
  output logic [REQ_DATA_WIDTH-1:0]           arbiter_req_data,
  output logic                                arbiter_req,
  input  logic                                server_stall,
  input  logic [SERVER_DATA_WIDTH-1:0]        server_data,
  input  logic                                server_ready,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
  output logic                                spurious_ready
);

  localparam int unsigned IDW = id_width(N_CLIENTS);

  logic [IDW-1:0]               ptr_q, ptr_d;
  logic [N_CLIENTS-1:0]         pending_q, pending_d;
  logic [N_CLIENTS-1:0]         readies_q, readies_d;
  logic                         req_q, req_d;
  logic [REQ_DATA_WIDTH-1:0]    req_data_q, req_data_d;
  logic [SERVER_DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                         spurious_q, spurious_d;

  logic [N_CLIENTS-1:0]         eligible;
  logic [IDW-1:0]               winner;
  logic [REQ_DATA_WIDTH-1:0]    winner_data;
  logic                         issue;
  logic                         pop;
  logic [IDW-1:0]               head;
  logic                         fifo_full;
  logic                         fifo_empty;

  tag_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .WIDTH(IDW)
  ) u_tag_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (issue),
    .push_data_i(winner),
    .pop_i      (pop),
    .pop_data_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (outstanding)
  );

  always_comb begin
    // readies_q masks a client whose pending bit was cleared at the same edge its pulse rose
    eligible = reqs & ~pending_q & ~readies_q;
    winner   = IDW'(rr_find_first(RR_MAX_N'(eligible), N_CLIENTS, 32'(ptr_q)));
    issue    = (|eligible) && !fifo_full && !server_stall;
    pop      = server_ready && !fifo_empty;

    winner_data = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (winner == IDW'(i)) winner_data = req_data_flat[i*REQ_DATA_WIDTH +: REQ_DATA_WIDTH];
    end

    ptr_d      = ptr_q;
    req_d      = issue;
    req_data_d = req_data_q;
    pending_d  = pending_q;
    readies_d  = '0;
    data_out_d = data_out_q;
    spurious_d = spurious_q | (server_ready && fifo_empty);

    // The popped head is already pending, so it can never equal the winner.
    if (pop) begin
      pending_d[head] = 1'b0;
      readies_d[head] = 1'b1;
      data_out_d      = server_data;
    end
    if (issue) begin
      pending_d[winner] = 1'b1;
      req_data_d        = winner_data;
      ptr_d             = (winner == IDW'(N_CLIENTS - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      pending_q  <= '0;
      readies_q  <= '0;
      req_q      <= 1'b0;
      req_data_q <= '0;
      data_out_q <= '0;
      spurious_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      pending_q  <= pending_d;
      readies_q  <= readies_d;
      req_q      <= req_d;
      req_data_q <= req_data_d;
      data_out_q <= data_out_d;
      spurious_q <= spurious_d;
    end
  end

  assign readies          = readies_q;
  assign arbiter_req      = req_q;
  assign arbiter_req_data = req_data_q;
  assign data_out         = data_out_q;
  assign spurious_ready   = spurious_q;

endmodule

// File: tb/tb_pipelined_rr_arbiter.sv
// Directed bench for pipelined_rr_arbiter with hand-computed expectations.
module tb_pipelined_rr_arbiter;

  localparam int unsigned RW = 16;
  localparam int unsigned SW = 16;
  localparam int unsigned N  = 32;
  localparam int unsigned MO = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*RW-1:0] req_data_flat;
  logic [N-1:0]    reqs;
  logic [SW-1:0]   data_out;
  logic [N-1:0]    readies;
  logic [RW-1:0]   arbiter_req_data;
  logic            arbiter_req;
  logic            server_stall;
  logic [SW-1:0]   server_data;
  logic            server_ready;
  logic [2:0]      outstanding;
  logic            spurious_ready;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipelined_rr_arbiter #(
    .REQ_DATA_WIDTH   (RW),
    .SERVER_DATA_WIDTH(SW),
    .N_CLIENTS        (N),
    .MAX_OUTSTANDING  (MO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_data_flat   (req_data_flat),
    .reqs            (reqs),
    .data_out        (data_out),
    .readies         (readies),
    .arbiter_req_data(arbiter_req_data),
    .arbiter_req     (arbiter_req),
    .server_stall    (server_stall),
    .server_data     (server_data),
    .server_ready    (server_ready),
    .outstanding     (outstanding),
    .spurious_ready  (spurious_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input logic [RW-1:0] data, input logic [2:0] outs);
    chk({tag, "_req"}, 64'(arbiter_req), 64'd1);
    chk({tag, "_data"}, 64'(arbiter_req_data), 64'(data));
    chk({tag, "_outs"}, 64'(outstanding), 64'(outs));
  endtask

  task automatic chk_resp(input string tag, input logic [N-1:0] rdy, input logic [SW-1:0] d,
                          input logic [2:0] outs);
    chk({tag, "_readies"}, 64'(readies), 64'(rdy));
    chk({tag, "_dout"}, 64'(data_out), 64'(d));
    chk({tag, "_outs"}, 64'(outstanding), 64'(outs));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 64'(arbiter_req), 64'd0);
    chk({tag, "_rdata"}, 64'(arbiter_req_data), 64'd0);
    chk({tag, "_readies"}, 64'(readies), 64'd0);
    chk({tag, "_dout"}, 64'(data_out), 64'd0);
    chk({tag, "_outs"}, 64'(outstanding), 64'd0);
    chk({tag, "_spur"}, 64'(spurious_ready), 64'd0);
  endtask

  initial begin
    reset         = 1'b0;
    req_data_flat = '0;
    reqs          = '0;
    server_stall  = 1'b0;
    server_data   = '0;
    server_ready  = 1'b0;
    tick();
    tick();
    chk_zero("rst0");
    reset = 1'b1;

    // Single client, server latency 3
    req_data_flat[15:0] = 16'h0042;
    reqs = 32'h1;
    tick(); chk_issue("s1_issue", 16'h0042, 3'd1);
    tick(); chk("s1_noissue1", 64'(arbiter_req), 64'd0);
    tick(); chk("s1_noissue2", 64'(arbiter_req), 64'd0);
    server_ready = 1'b1; server_data = 16'hBEEF;
    tick(); chk_resp("s1_resp", 32'h1, 16'hBEEF, 3'd0);
    chk("s1_noissue3", 64'(arbiter_req), 64'd0);
    server_ready = 1'b0;
    tick(); chk("s1_masked", 64'(arbiter_req), 64'd0);
    chk("s1_pulse_end", 64'(readies), 64'd0);
    tick(); chk_issue("s1_reissue", 16'h0042, 3'd1);
    reqs = '0; server_ready = 1'b1; server_data = 16'h1234;
    tick(); chk_resp("s1_resp2", 32'h1, 16'h1234, 3'd0);
    server_ready = 1'b0;

    reset = 1'b0;
    tick();
    chk_zero("rst1");
    reset = 1'b1;

    // Fairness and pipelining with all clients requesting
    for (int i = 0; i < int'(N); i++) req_data_flat[i*RW +: RW] = 16'(16'h0100 + i);
    reqs = '1;
    tick(); chk_issue("f_g0", 16'h0100, 3'd1);
    tick(); chk_issue("f_g1", 16'h0101, 3'd2);
    tick(); chk_issue("f_g2", 16'h0102, 3'd3);
    tick(); chk_issue("f_g3", 16'h0103, 3'd4);
    tick(); chk("f_sat_req", 64'(arbiter_req), 64'd0);
    chk("f_sat_outs", 64'(outstanding), 64'd4);
    server_ready = 1'b1; server_data = 16'h00D0;
    tick(); chk_resp("f_r0", 32'h1, 16'h00D0, 3'd3);
    chk("f_r0_req", 64'(arbiter_req), 64'd0);
    server_ready = 1'b0;
    tick(); chk_issue("f_g4", 16'h0104, 3'd4);
    server_ready = 1'b1; server_data = 16'h00D1;
    tick(); chk_resp("f_r1", 32'h2, 16'h00D1, 3'd3);
    server_data = 16'h00D2;
    tick(); chk_issue("f_sim", 16'h0105, 3'd3);
    chk("f_sim_readies", 64'(readies), 64'h4);
    chk("f_sim_dout", 64'(data_out), 64'h00D2);
    reqs = '0; server_data = 16'h00D3;
    tick(); chk_resp("f_r3", 32'h8, 16'h00D3, 3'd2);
    server_data = 16'h00D4;
    tick(); chk_resp("f_r4", 32'h10, 16'h00D4, 3'd1);
    server_data = 16'h00D5;
    tick(); chk_resp("f_r5", 32'h20, 16'h00D5, 3'd0);
    server_ready = 1'b0;

    // Back-pressure
    reqs = 32'h1; server_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req", 64'(arbiter_req), 64'd0);
    end
    server_stall = 1'b0;
    tick(); chk_issue("stall_rel", 16'h0100, 3'd1);
    reqs = '0; server_ready = 1'b1; server_data = 16'h005A;
    tick(); chk_resp("stall_resp", 32'h1, 16'h005A, 3'd0);
    chk("spur_pre", 64'(spurious_ready), 64'd0);

    // Spurious response with empty FIFO
    tick(); chk_resp("spur", 32'h0, 16'h005A, 3'd0);
    chk("spur_set", 64'(spurious_ready), 64'd1);
    server_ready = 1'b0;
    tick(); chk("spur_sticky", 64'(spurious_ready), 64'd1);
    reset = 1'b0;
    #1; chk("spur_clr", 64'(spurious_ready), 64'd0);
    tick();
    reset = 1'b1;

    // Wrap-around from pointer 30
    reqs = 32'h2000_0000;
    tick(); chk_issue("w_g29", 16'h011D, 3'd1);
    reqs = '0; server_ready = 1'b1; server_data = 16'h0077;
    tick(); chk_resp("w_r29", 32'h2000_0000, 16'h0077, 3'd0);
    server_ready = 1'b0; reqs = 32'h8000_0004;
    tick(); chk_issue("w_g31", 16'h011F, 3'd1);
    tick(); chk_issue("w_g2", 16'h0102, 3'd2);
    reqs = '0; server_ready = 1'b1; server_data = 16'h00A1;
    tick(); chk_resp("w_r31", 32'h8000_0000, 16'h00A1, 3'd1);
    server_data = 16'h00A2;
    tick(); chk_resp("w_r2", 32'h4, 16'h00A2, 3'd0);
    server_ready = 1'b0;

    // Reset with three requests in flight
    reqs = 32'h7;
    tick(); chk_issue("m_g0", 16'h0100, 3'd1);
    tick(); chk_issue("m_g1", 16'h0101, 3'd2);
    tick(); chk_issue("m_g2", 16'h0102, 3'd3);
    reqs = '0;
    reset = 1'b0;
    #1; chk_zero("m_rst");
    tick();
    reset = 1'b1;
    server_ready = 1'b1; server_data = 16'h0099;
    tick(); chk_resp("m_late", 32'h0, 16'h0000, 3'd0);
    chk("m_late_spur", 64'(spurious_ready), 64'd1);
    server_ready = 1'b0; reqs = 32'h22;
    tick(); chk_issue("m_g1_new", 16'h0101, 3'd1);
    tick(); chk_issue("m_g5_new", 16'h0105, 3'd2);
    reqs = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
